// File: rtl/axi_slave_mem_responder.sv
// rtl/axi_slave_mem_responder.sv - AXI4 slave responder backed by an internal word-addressed memory
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst each.
module axi_slave_mem_responder #(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_DEPTH * STRB_W);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> SHIFT);
  endfunction

  // Anything other than full-width FIXED/INCR is rejected for the whole burst.
  function automatic logic bad_burst(input logic [1:0] burst, input logic [2:0] size);
    return ((burst != 2'b00) && (burst != 2'b01)) || (size != 3'(SHIFT));
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write engine ----------------
  w_state_t              w_state, w_next;
  logic                  aw_ready;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len, wr_cnt;
  logic                  wr_incr, wr_berr;
  logic [1:0]            wr_resp;
  logic                  aw_hs, w_hs, w_last_beat, w_we;
  logic [1:0]            w_beat_resp, w_last_resp;

  assign AWREADY = aw_ready;
  assign WREADY  = (w_state == W_DATA);
  assign BVALID  = (w_state == W_RESP);
  assign BID     = BVALID ? wr_id : '0;
  assign BRESP   = BVALID ? wr_resp : RESP_OKAY;

  assign aw_hs       = AWVALID && aw_ready;
  assign w_hs        = WVALID && WREADY;
  assign w_last_beat = (wr_cnt == wr_len);
  assign w_beat_resp = wr_berr ? RESP_SLVERR : (in_range(wr_addr) ? RESP_OKAY : RESP_DECERR);
  assign w_last_resp = (WLAST != w_last_beat) ? RESP_SLVERR : RESP_OKAY;
  assign w_we        = w_hs && (w_beat_resp == RESP_OKAY);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_ready <= 1'b0;
      wr_id    <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_cnt   <= '0;
      wr_incr  <= 1'b0;
      wr_berr  <= 1'b0;
      wr_resp  <= RESP_OKAY;
    end else begin
      aw_ready <= (w_next == W_IDLE);
      if (aw_hs) begin
        wr_id   <= AWID;
        wr_addr <= AWADDR;
        wr_len  <= AWLEN;
        wr_cnt  <= '0;
        wr_incr <= (AWBURST == 2'b01);
        wr_berr <= bad_burst(AWBURST, AWSIZE);
        wr_resp <= RESP_OKAY;
      end else if (w_hs) begin
        wr_cnt  <= wr_cnt + 8'd1;
        wr_addr <= wr_incr ? wr_addr + STEP : wr_addr;
        wr_resp <= resp_max(wr_resp, resp_max(w_beat_resp, w_last_resp));
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[word_index(wr_addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t              r_state, r_next;
  logic                  ar_ready;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_len, rd_cnt;
  logic                  rd_incr, rd_berr;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;
  logic                  ar_hs, r_hs, r_load, r_fetch_berr, r_fetch_ok;
  logic [ADDR_WIDTH-1:0] r_fetch_addr;
  logic [1:0]            r_fetch_resp;

  assign ARREADY = ar_ready;
  assign RVALID  = (r_state == R_DATA);
  assign RID     = rd_id;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

  assign ar_hs  = ARVALID && ar_ready;
  assign r_hs   = RVALID && RREADY;
  assign r_load = ar_hs || (r_hs && !rlast_q);

  // The next beat is fetched on the handshake edge so the R registers only change when accepted.
  assign r_fetch_addr = ar_hs ? ARADDR : (rd_incr ? rd_addr + STEP : rd_addr);
  assign r_fetch_berr = ar_hs ? bad_burst(ARBURST, ARSIZE) : rd_berr;
  assign r_fetch_ok   = !r_fetch_berr && in_range(r_fetch_addr);
  assign r_fetch_resp = r_fetch_berr ? RESP_SLVERR : (r_fetch_ok ? RESP_OKAY : RESP_DECERR);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ar_ready <= 1'b0;
      rd_id    <= '0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_cnt   <= '0;
      rd_incr  <= 1'b0;
      rd_berr  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      ar_ready <= (r_next == R_IDLE);
      if (r_load) begin
        rdata_q <= r_fetch_ok ? mem[word_index(r_fetch_addr)] : '0;
        rresp_q <= r_fetch_resp;
        rd_addr <= r_fetch_addr;
      end
      if (ar_hs) begin
        rd_id   <= ARID;
        rd_len  <= ARLEN;
        rd_cnt  <= '0;
        rd_incr <= (ARBURST == 2'b01);
        rd_berr <= bad_burst(ARBURST, ARSIZE);
        rlast_q <= (ARLEN == 8'd0);
      end else if (r_hs && !rlast_q) begin
        rd_cnt  <= rd_cnt + 8'd1;
        rlast_q <= ((rd_cnt + 8'd1) == rd_len);
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// tb/tb_axi_slave_mem_responder.sv - randomized self-checking bench for axi_slave_mem_responder
// A byte-level memory model predicts every B and R response from the burst rules.
module tb_axi_slave_mem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;

  axi_slave_mem_responder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint beat_addr(input logic [31:0] a, input int i, input logic [1:0] burst);
    return (burst == 2'b01) ? longint'(a) + 4 * i : longint'(a);
  endfunction

  function automatic bit addr_ok(input longint a);
    return (a >= longint'(BASE)) && ((a - longint'(BASE)) / 4 < DEPTH);
  endfunction

  function automatic bit burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == 2'b00 || burst == 2'b01) || size != 3'd2;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, AWREADY, 0);
    check({tag, "_arready"}, ARREADY, 0);
    check({tag, "_wready"},  WREADY, 0);
    check({tag, "_bvalid"},  BVALID, 0);
    check({tag, "_bid_bresp"}, {BID, BRESP}, 0);
    check({tag, "_rvalid"},  RVALID, 0);
    check({tag, "_r_fields"}, {RID, RDATA, RRESP, RLAST}, 0);
  endtask

  // wl_mode: 0 = WLAST on final beat, 1 = WLAST on first beat only, 2 = WLAST never
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int wl_mode, input int b_hold);
    logic [1:0] exp_resp, er;
    logic       wl;
    longint     a;
    int         t;
    exp_resp = 2'b00;
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
    check("aw_wait", t < 50, 1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wl = (wl_mode == 0) ? (i == len) : (wl_mode == 1) ? (i == 0) : 1'b0;
      WDATA = wbuf[i]; WSTRB = sbuf[i]; WLAST = wl; WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
      if (t >= 50) check("w_wait", 0, 1);
      @(negedge ACLK);
      a = beat_addr(addr, i, burst);
      if (burst_bad(burst, size)) er = 2'b10;
      else if (!addr_ok(a)) er = 2'b11;
      else begin
        er = 2'b00;
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) ref_mem[(a - longint'(BASE)) / 4][8*b +: 8] = wbuf[i][8*b +: 8];
      end
      if (er > exp_resp) exp_resp = er;
      if (wl != (i == len) && exp_resp < 2'b10) exp_resp = 2'b10;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    t = 0;
    while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
    check("b_wait", t < 50, 1);
    for (int h = 0; h < b_hold; h++) begin
      check("bvalid_hold", BVALID, 1);
      check("bid_hold", {BID, BRESP}, {id, exp_resp});
      @(negedge ACLK);
    end
    check("bid", BID, id);
    check("bresp", BRESP, exp_resp);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("bvalid_drop", BVALID, 0);
    check("awready_after_b", AWREADY, 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_cycles);
    logic [31:0] ed;
    logic [1:0]  er;
    longint      a;
    int          t;
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    check("ar_wait", t < 50, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("rvalid_latency", RVALID, 1);
    for (int i = 0; i <= len; i++) begin
      t = 0;
      while (!RVALID && t < 50) begin @(negedge ACLK); t++; end
      if (t >= 50) check("r_wait", 0, 1);
      a = beat_addr(addr, i, burst);
      if (burst_bad(burst, size)) begin ed = '0; er = 2'b10; end
      else if (!addr_ok(a)) begin ed = '0; er = 2'b11; end
      else begin ed = ref_mem[(a - longint'(BASE)) / 4]; er = 2'b00; end
      check("rdata", RDATA, ed);
      check("rresp", RRESP, er);
      check("rlast", RLAST, (i == len));
      check("rid", RID, id);
      if (i == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge ACLK);
          check("r_hold", {RVALID, RID, RDATA, RRESP, RLAST}, {1'b1, id, ed, er, (i == len)});
        end
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
    check("rvalid_end", RVALID, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge ACLK);
    check_idle_outputs("reset");
    ARESET = 1'b0;
    @(negedge ACLK);
    check("awready_post_reset", AWREADY, 1);
    check("arready_post_reset", ARREADY, 1);

    // Fill the whole memory with one 256-beat burst and read it back.
    for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(4'h1, BASE, 255, 3'd2, 2'b01, 0, 0);
    do_read(4'h2, BASE, 255, 3'd2, 2'b01, -1, 0);

    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; end
    do_write(4'h3, BASE + 32'h10, 3, 3'd2, 2'b01, 0, 0);
    do_read(4'h4, BASE + 32'h10, 3, 3'd2, 2'b01, -1, 0);

    wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
    do_write(4'h5, BASE + 32'h20, 0, 3'd2, 2'b01, 0, 0);
    wbuf[0] = 32'h1234_5678; sbuf[0] = 4'b0101;
    do_write(4'h5, BASE + 32'h20, 0, 3'd2, 2'b01, 0, 0);
    do_read(4'h6, BASE + 32'h20, 0, 3'd2, 2'b01, -1, 0);
    check("strobe_merge", RDATA, 32'hFF34_FF78);

    do_read(4'h7, BASE + (DEPTH - 2) * 4, 3, 3'd2, 2'b01, -1, 0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(4'h8, BASE + (DEPTH - 2) * 4, 3, 3'd2, 2'b01, 0, 0);
    do_read(4'h9, BASE + (DEPTH - 4) * 4, 3, 3'd2, 2'b01, -1, 0);

    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(4'hA, BASE + 32'h10, 3, 3'd2, 2'b10, 0, 0);
    do_read(4'hA, BASE + 32'h10, 3, 3'd2, 2'b01, -1, 0);
    do_write(4'hB, BASE + 32'h40, 1, 3'd2, 2'b01, 1, 0);
    do_read(4'hB, BASE + 32'h40, 1, 3'd2, 2'b01, -1, 0);
    do_write(4'hC, BASE + 32'h50, 1, 3'd1, 2'b01, 0, 0);
    do_write(4'hD, BASE + 32'h60, 3, 3'd2, 2'b00, 0, 0);
    do_read(4'hD, BASE + 32'h60, 2, 3'd2, 2'b00, -1, 0);

    do_read(4'hE, BASE, 7, 3'd2, 2'b01, 2, 5);
    do_write(4'hF, BASE + 32'h80, 3, 3'd2, 2'b01, 0, 3);

    // Concurrent AW/AR acceptance, then reset in the middle of the read burst.
    @(negedge ACLK);
    AWID = 4'h3; AWADDR = BASE + 32'h100; AWLEN = 8'd1; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    ARID = 4'h5; ARADDR = BASE; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    check("concurrent_ready", {AWREADY, ARREADY}, 2'b11);
    @(negedge ACLK);
    AWVALID = 1'b0; ARVALID = 1'b0;
    check("concurrent_accept", {AWREADY, ARREADY, WREADY, RVALID}, 4'b0011);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check("mid_burst_rvalid", RVALID, 1);
    #2 ARESET = 1'b1;
    #1 check_idle_outputs("async_reset");
    @(negedge ACLK);
    check_idle_outputs("held_reset");
    ARESET = 1'b0;
    @(negedge ACLK);
    check("awready_after_pulse", AWREADY, 1);
    check("arready_after_pulse", ARREADY, 1);
    check("no_stale_beats", {WREADY, RVALID, BVALID}, 3'b000);
    for (int i = 0; i < 2; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(4'h6, BASE + 32'h100, 1, 3'd2, 2'b01, 0, 0);
    do_read(4'h7, BASE + 32'hF8, 5, 3'd2, 2'b01, -1, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      int          rl, bsel, ssel, wm;
      logic [1:0]  rb;
      logic [2:0]  rs;
      ra   = BASE + 4 * $urandom_range(0, DEPTH + 3) + $urandom_range(0, 3);
      rl   = $urandom_range(0, 7);
      bsel = $urandom_range(0, 9);
      rb   = (bsel < 7) ? 2'b01 : (bsel < 9) ? 2'b00 : 2'(2 + $urandom_range(0, 1));
      ssel = $urandom_range(0, 9);
      rs   = (ssel == 0) ? 3'd1 : 3'd2;
      wm   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      for (int i = 0; i <= rl; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
      do_write(4'($urandom), ra, rl, rs, rb, wm, $urandom_range(0, 2));
      do_read(4'($urandom), ra, rl, 3'd2, (rb == 2'b00) ? 2'b00 : 2'b01,
              $urandom_range(0, 7), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
